// File: rtl/button_debouncer.sv
// Multi-button debouncer: 2-flop synchronizer, shared sample-tick prescaler,
// per-button stability filter, press/release edge pulses and auto-repeat.
module button_debouncer #(
  parameter int N_BTN        = 4,
  parameter int TICK_PRESC   = 60_000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_event,
  output logic             tick
);

  localparam int PW = $clog2(TICK_PRESC);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [N_BTN-1:0] IDLE_RAW = {N_BTN{ACTIVE_LOW}};

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] pressed;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_en;
  logic             tick_q;
  logic [N_BTN-1:0] state_q, state_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             any_q, any_d;
  logic [SW-1:0]    stab_q [N_BTN];
  logic [SW-1:0]    stab_d [N_BTN];
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];

  always_comb begin
    pressed   = ACTIVE_LOW ? ~sync2_q : sync2_q;
    tick_en   = (presc_q == '0);
    presc_d   = tick_en ? PW'(TICK_PRESC - 1) : presc_q - 1'b1;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    stab_d    = stab_q;
    hold_d    = hold_q;
    for (int i = 0; i < N_BTN; i++) begin
      // A change is accepted only after STABLE_TICKS consecutive differing samples.
      if (tick_en) begin
        if (pressed[i] == state_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == SW'(STABLE_TICKS - 1)) begin
          stab_d[i]    = '0;
          state_d[i]   = ~state_q[i];
          press_d[i]   = ~state_q[i];
          release_d[i] = state_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 1'b1;
        end
      end
      // The release tick clears the hold count and never also repeats.
      if (!state_q[i] || release_d[i]) begin
        hold_d[i] = '0;
      end else if (tick_en && (REPEAT_DELAY != 0)) begin
        if (hold_q[i] + 1'b1 == HW'(REPEAT_DELAY)) begin
          repeat_d[i] = 1'b1;
          hold_d[i]   = HW'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
    any_d = |{press_d, release_d, repeat_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= IDLE_RAW;
      sync2_q   <= IDLE_RAW;
      presc_q   <= PW'(TICK_PRESC - 1);
      tick_q    <= 1'b0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      tick_q    <= tick_en;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign any_event   = any_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with a 4-cycle tick, 3-tick filter and 5/2 repeat.
// Expected output events are queued with their cycle number when stimulus is applied.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_state, btn_press, btn_release, btn_repeat;
  logic       any_event, tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Event record: {cycle[15:0], state, press, release, repeat}
  typedef logic [31:0] ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [3:0] raw;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
  } vec_t;
  vec_t vecs[7];

  button_debouncer #(
    .N_BTN(4), .TICK_PRESC(4), .STABLE_TICKS(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_event(any_event), .tick(tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset was last sampled low; tick is expected when cyc%4==0.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic ev_t mk_ev(int c, logic [3:0] st, logic [3:0] pr,
                                logic [3:0] rl, logic [3:0] rp);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, st, pr, rl, rp};
  endfunction

  task automatic monitor();
    ev_t act;
    ev_t exp_ev;
    if (mon_en && cyc != 0) begin
      checks++;
      if (tick !== (cyc % 4 == 0)) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, (cyc % 4 == 0));
      end
      if ((btn_press | btn_release | btn_repeat) != 4'h0 || any_event !== 1'b0) begin
        act = mk_ev(cyc, btn_state, btn_press, btn_release, btn_repeat);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h any=%b", act, any_event);
        end else begin
          exp_ev = exp_q.pop_front();
          if (act !== exp_ev || any_event !== 1'b1) begin
            errors++;
            $display("FAIL event got=%h any=%b want=%h any=1", act, any_event, exp_ev);
          end
        end
      end
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic check_state(string name, logic [3:0] want);
    checks++;
    if (btn_state !== want) begin
      errors++;
      $display("FAIL %s btn_state got=%b want=%b", name, btn_state, want);
    end
  endtask

  task automatic check_reset_outputs(string name);
    checks++;
    if ({btn_state, btn_press, btn_release, btn_repeat, any_event, tick} !== 18'h0) begin
      errors++;
      $display("FAIL %s outputs got=%h want=0", name,
               {btn_state, btn_press, btn_release, btn_repeat, any_event, tick});
    end
  endtask

  // Repeats come at hold ticks 5,7,9,11 after the press at cycle p.
  task automatic push_press_and_repeats(int p);
    exp_q.push_back(mk_ev(p, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
    for (int k = 5; k <= 11; k += 2)
      exp_q.push_back(mk_ev(p + 4 * k, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
  endtask

  initial begin
    int c;
    vecs[0] = '{raw: 4'b1110, press: 4'b0001, rel: 4'b0000, state: 4'b0001};
    vecs[1] = '{raw: 4'b1111, press: 4'b0000, rel: 4'b0001, state: 4'b0000};
    vecs[2] = '{raw: 4'b0000, press: 4'b1111, rel: 4'b0000, state: 4'b1111};
    vecs[3] = '{raw: 4'b1111, press: 4'b0000, rel: 4'b1111, state: 4'b0000};
    vecs[4] = '{raw: 4'b1010, press: 4'b0101, rel: 4'b0000, state: 4'b0101};
    vecs[5] = '{raw: 4'b0101, press: 4'b1010, rel: 4'b0101, state: 4'b1010};
    vecs[6] = '{raw: 4'b1111, press: 4'b0000, rel: 4'b1010, state: 4'b0000};

    reset   = 1'b1;
    btn_raw = 4'hF;
    step(3);
    check_reset_outputs("power_on_reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: ticks at 4, 8, 12, 16 and nothing else.
    step(16);
    check_state("idle", 4'h0);

    // Table: each change lands on the third sampling tick, 12 cycles after a tick boundary.
    foreach (vecs[i]) begin
      c = cyc;
      btn_raw = vecs[i].raw;
      if ((vecs[i].press | vecs[i].rel) != 4'h0)
        exp_q.push_back(mk_ev(c + 12, vecs[i].state, vecs[i].press, vecs[i].rel, 4'h0));
      step(16);
      check_state($sformatf("vec%0d", i), vecs[i].state);
    end

    // Bounce on button 1: two low samples, one high, two low, then high.
    btn_raw = 4'b1101; step(8);
    btn_raw = 4'b1111; step(4);
    btn_raw = 4'b1101; step(8);
    btn_raw = 4'b1111; step(12);
    check_state("bounce", 4'h0);

    // Auto-repeat on button 2, released so the release lands on hold tick 12.
    c = cyc;
    btn_raw = 4'b1011;
    push_press_and_repeats(c + 12);
    step(48);
    btn_raw = 4'hF;
    exp_q.push_back(mk_ev(c + 60, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    step(32);
    check_state("repeat_release", 4'h0);

    // Release landing exactly on a would-be repeat tick (hold tick 13).
    c = cyc;
    btn_raw = 4'b1011;
    push_press_and_repeats(c + 12);
    step(52);
    btn_raw = 4'hF;
    exp_q.push_back(mk_ev(c + 64, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    step(32);
    check_state("repeat_coincident_release", 4'h0);

    // Reset while button 3 is held: one fresh press after re-debounce.
    c = cyc;
    btn_raw = 4'b0111;
    exp_q.push_back(mk_ev(c + 12, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    step(20);
    check_state("pre_reset_hold", 4'b1000);
    reset = 1'b1;
    step(1);
    check_reset_outputs("mid_hold_reset_a");
    step(1);
    check_reset_outputs("mid_hold_reset_b");
    reset = 1'b0;
    exp_q.push_back(mk_ev(12, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    step(16);
    check_state("post_reset_press", 4'b1000);
    btn_raw = 4'hF;
    exp_q.push_back(mk_ev(28, 4'b0000, 4'b0000, 4'b1000, 4'b0000));
    step(24);
    check_state("post_reset_release", 4'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button inputs.
REQ-002 SHALL have parameter TICK_PRESC, default 60_000: clk cycles per sample tick, at least 2.
REQ-003 SHALL have parameter STABLE_TICKS, default 10: consecutive differing ticks needed to accept a change, at least 1.
REQ-004 SHALL have parameter REPEAT_DELAY, default 500: ticks held before the first repeat; 0 disables repeat.
REQ-005 SHALL have parameter REPEAT_RATE, default 100: ticks between later repeats, 1 to REPEAT_DELAY.
REQ-006 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw 0 is pressed.
REQ-007 SHALL have port clk, input, 1 bit: sole clock.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port btn_raw, input, N_BTN bits: asynchronous, bouncing button pins.
REQ-010 SHALL have port btn_state, output, N_BTN bits: debounced level, 1 means pressed.
REQ-011 SHALL have port btn_press, output, N_BTN bits: one-cycle pulse on each accepted press.
REQ-012 SHALL have port btn_release, output, N_BTN bits: one-cycle pulse on each accepted release.
REQ-013 SHALL have port btn_repeat, output, N_BTN bits: one-cycle auto-repeat pulse while held.
REQ-014 SHALL have port any_event, output, 1 bit: OR of all press, release and repeat bits in the same cycle.
REQ-015 SHALL have port tick, output, 1 bit: one-cycle sample strobe.

Function
REQ-016 SHALL pass each btn_raw bit through a 2-flop synchronizer, then invert it when ACTIVE_LOW=1; the result is sync[i], 1 = pressed.
REQ-017 SHALL implement the prescaler as a down-counter: load TICK_PRESC-1 on reset, decrement each cycle, assert tick while it equals 0, then reload.
REQ-018 SHALL therefore raise the first tick TICK_PRESC cycles after reset deasserts, and then every TICK_PRESC cycles.
REQ-019 SHALL keep a per-button stability counter of width $clog2(STABLE_TICKS+1), updated only on tick cycles.
REQ-020 SHALL, on a tick where sync[i] equals btn_state[i], clear that counter to 0.
REQ-021 SHALL, on a tick where sync[i] differs from btn_state[i], increment the counter.
REQ-022 SHALL, when that increment reaches STABLE_TICKS, toggle btn_state[i] at the same edge and clear the counter.
REQ-023 SHALL ignore any input excursion lasting fewer than STABLE_TICKS consecutive ticks.
REQ-024 SHALL pulse btn_press[i] or btn_release[i] high for exactly the cycle after the edge where btn_state[i] toggles.
REQ-025 SHALL keep a per-button hold counter of width $clog2(REPEAT_DELAY+1), cleared whenever btn_state[i]=0 and on the press edge.
REQ-026 SHALL increment the hold counter on each tick while btn_state[i]=1.
REQ-027 SHALL, when the increment equals REPEAT_DELAY, pulse btn_repeat[i] in the next cycle and reload the hold counter with REPEAT_DELAY-REPEAT_RATE.
REQ-028 SHALL stop repeat pulses at release, with no repeat in the same cycle as the release pulse.
REQ-029 SHALL never pulse btn_repeat when REPEAT_DELAY=0.
REQ-030 SHALL process all buttons independently: simultaneous events on several bits are each reported in the same cycle, and any_event is their registered OR.
REQ-031 SHALL make all outputs registered, with no combinational path from btn_raw.

Reset
REQ-032 SHALL, while reset=1, drive btn_state, btn_press, btn_release, btn_repeat, any_event and tick to 0.
REQ-033 SHALL, on reset, clear all stability and hold counters and load the prescaler with TICK_PRESC-1.
REQ-034 SHALL, on reset, preset the synchronizer flops to the released raw level (1 when ACTIVE_LOW=1) so that no spurious press appears after reset.
REQ-035 SHALL, when reset is asserted mid-debounce or mid-hold, abandon that state: a button still held after reset deasserts is re-debounced from zero and reports one fresh press.

Verification (TICK_PRESC=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, ACTIVE_LOW=1, N_BTN=4)
REQ-036 SHALL cover tick timing: release reset with btn_raw held at 4'hF -> tick pulses at cycles 4, 8, 12 after reset deasserts, and every other output stays 0.
REQ-037 SHALL cover clean press: drive btn_raw[0]=0 and hold it -> btn_state[0] rises on the 3rd tick that samples it pressed, and btn_press[0] and any_event pulse for exactly 1 cycle.
REQ-038 SHALL cover bounce rejection: btn_raw[1] low for 2 ticks, then high, then low for 2 ticks -> btn_state[1] stays 0 and no pulses occur.
REQ-039 SHALL cover auto-repeat: hold btn_raw[2] low for 12 ticks after acceptance -> btn_repeat[2] pulses at hold ticks 5, 7, 9 and 11; release then gives 1 btn_release[2] pulse and no further repeats.
REQ-040 SHALL cover simultaneous press: btn_raw=4'b0000 in one cycle -> btn_press=4'hF in a single cycle and any_event=1 for that cycle.
REQ-041 SHALL cover reset mid-hold: reset while btn_state[3]=1 with btn_raw[3] still low -> outputs 0 during reset, then exactly one new btn_press[3] after 3 ticks.
